// File: rtl/ft_tx_arbiter.sv
// Two-requester round-robin arbiter feeding the FT245 core TX FIFO.
// Bursts end on packet last, burst length limit, or requester stall timeout.
module ft_tx_arbiter #(
    parameter int unsigned BURST_MAX = 16,
    parameter int unsigned STALL_MAX = 64
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] req_data0,
    input  logic [31:0] req_data1,
    input  logic        req_last0,
    input  logic        req_last1,
    output logic        ack0,
    output logic        ack1,
    input  logic        tx_valid,
    output logic        tx_write,
    output logic [31:0] tx_data,
    output logic [1:0]  grant,
    output logic [15:0] word_cnt0,
    output logic [15:0] word_cnt1
);

    // state   | meaning
    // S_IDLE  | no owner, arbitrate on req0/req1 with rr
    // S_XFER0 | requester 0 owns the TX FIFO
    // S_XFER1 | requester 1 owns the TX FIFO
    // S_GAP   | one dead cycle after every burst
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER0 = 2'd1,
        S_XFER1 = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [7:0] LP_BURST = 8'(BURST_MAX);
    localparam logic [7:0] LP_STALL = 8'(STALL_MAX);

    state_t      r_state;
    logic        r_rr;
    logic [7:0]  r_bcnt;
    logic [7:0]  r_stall;
    logic [1:0]  r_grant;
    logic [15:0] r_wcnt0;
    logic [15:0] r_wcnt1;

    logic        w_in_xfer;
    logic        w_sel1;
    logic        w_req;
    logic        w_last;
    logic        w_write;
    logic [7:0]  w_bcnt_nxt;
    logic [7:0]  w_stall_nxt;
    logic        w_exit;

    assign w_in_xfer   = (r_state == S_XFER0) || (r_state == S_XFER1);
    assign w_sel1      = (r_state == S_XFER1);
    assign w_req       = w_sel1 ? req1 : req0;
    assign w_last      = w_sel1 ? req_last1 : req_last0;
    assign w_write     = w_in_xfer && w_req && tx_valid;
    assign w_bcnt_nxt  = r_bcnt + 8'd1;
    assign w_stall_nxt = r_stall + 8'd1;

    // Burst ends after an accepted word that is last or fills the burst,
    // or when the owner has been silent for STALL_MAX cycles.
    assign w_exit = w_in_xfer &&
                    ((w_write && (w_last || (w_bcnt_nxt == LP_BURST))) ||
                     (!w_req && (w_stall_nxt == LP_STALL)));

    assign tx_write  = w_write;
    assign ack0      = w_write && !w_sel1;
    assign ack1      = w_write && w_sel1;
    assign tx_data   = !w_in_xfer ? 32'h0 : (w_sel1 ? req_data1 : req_data0);
    assign grant     = r_grant;
    assign word_cnt0 = r_wcnt0;
    assign word_cnt1 = r_wcnt1;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_rr    <= 1'b0;
            r_bcnt  <= 8'd0;
            r_stall <= 8'd0;
            r_grant <= 2'b00;
            r_wcnt0 <= 16'd0;
            r_wcnt1 <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_bcnt  <= 8'd0;
                    r_stall <= 8'd0;
                    if (req0 && (!req1 || !r_rr)) begin
                        r_state <= S_XFER0;
                        r_grant <= 2'b01;
                    end else if (req1) begin
                        r_state <= S_XFER1;
                        r_grant <= 2'b10;
                    end
                end
                S_XFER0, S_XFER1: begin
                    if (w_write) begin
                        r_bcnt  <= w_bcnt_nxt;
                        r_stall <= 8'd0;
                    end else if (!w_req) begin
                        r_stall <= w_stall_nxt;
                    end else begin
                        r_stall <= 8'd0;
                    end
                    if (w_exit) begin
                        r_state <= S_GAP;
                        r_grant <= 2'b00;
                        r_rr    <= !w_sel1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 2'b00;
                end
            endcase

            if (ack0 && (r_wcnt0 != 16'hFFFF))
                r_wcnt0 <= r_wcnt0 + 16'd1;
            if (ack1 && (r_wcnt1 != 16'hFFFF))
                r_wcnt1 <= r_wcnt1 + 16'd1;
        end
    end

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// Directed bench for ft_tx_arbiter: vector table plus multi-cycle sequences.
module tb_ft_tx_arbiter;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        req0, req1, req_last0, req_last1, tx_valid;
    logic [31:0] req_data0, req_data1;
    logic        ack0, ack1, tx_write;
    logic [31:0] tx_data;
    logic [1:0]  grant;
    logic [15:0] word_cnt0, word_cnt1;

    logic        s_req0, s_ack0, s_ack1, s_write;
    logic [31:0] s_data;
    logic [1:0]  s_grant;
    logic [15:0] s_wcnt0, s_wcnt1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    ft_tx_arbiter u_dut (
        .clk_in(clk_in), .rst(rst),
        .req0(req0), .req1(req1),
        .req_data0(req_data0), .req_data1(req_data1),
        .req_last0(req_last0), .req_last1(req_last1),
        .ack0(ack0), .ack1(ack1),
        .tx_valid(tx_valid), .tx_write(tx_write), .tx_data(tx_data),
        .grant(grant), .word_cnt0(word_cnt0), .word_cnt1(word_cnt1)
    );

    // Long bursts keep the saturation run short in cycles.
    ft_tx_arbiter #(.BURST_MAX(255), .STALL_MAX(64)) u_sat (
        .clk_in(clk_in), .rst(rst),
        .req0(s_req0), .req1(1'b0),
        .req_data0(32'h5A5A_0000), .req_data1(32'h0),
        .req_last0(1'b0), .req_last1(1'b0),
        .ack0(s_ack0), .ack1(s_ack1),
        .tx_valid(1'b1), .tx_write(s_write), .tx_data(s_data),
        .grant(s_grant), .word_cnt0(s_wcnt0), .word_cnt1(s_wcnt1)
    );

    typedef struct {
        logic        r0, r1, l0, l1, v;
        logic [31:0] d0, d1;
        logic [1:0]  g;
        logic        w, a0, a1;
        logic [31:0] td;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(logic r0, logic r1, logic l0, logic l1, logic v,
                                logic [31:0] d0, logic [31:0] d1, logic [1:0] g,
                                logic w, logic a0, logic a1, logic [31:0] td);
        vec_t t;
        t.r0 = r0; t.r1 = r1; t.l0 = l0; t.l1 = l1; t.v = v;
        t.d0 = d0; t.d1 = d1; t.g = g; t.w = w; t.a0 = a0; t.a1 = a1; t.td = td;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; req_last0 = 0; req_last1 = 0; tx_valid = 0;
        req_data0 = 0; req_data1 = 0; s_req0 = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_write"}, 32'(tx_write), 32'h0);
        chk({tag, "_acks"}, 32'({ack1, ack0}), 32'h0);
        chk({tag, "_data"}, tx_data, 32'h0);
        chk({tag, "_wcnt"}, {word_cnt1, word_cnt0}, 32'h0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        #1;
        chk_all_zero("reset");
        tick();
        tick();
        rst = 1;
    endtask

    task automatic step(input vec_t t, input int idx);
        req0 = t.r0; req1 = t.r1; req_last0 = t.l0; req_last1 = t.l1;
        tx_valid = t.v; req_data0 = t.d0; req_data1 = t.d1;
        #1;
        chk($sformatf("vec%0d_grant", idx), 32'(grant), 32'(t.g));
        chk($sformatf("vec%0d_write", idx), 32'(tx_write), 32'(t.w));
        chk($sformatf("vec%0d_ack0", idx), 32'(ack0), 32'(t.a0));
        chk($sformatf("vec%0d_ack1", idx), 32'(ack1), 32'(t.a1));
        chk($sformatf("vec%0d_data", idx), tx_data, t.td);
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        int idle_n, len, cnt, n, cyc;
        logic bad, bad_data, hit;
        logic [1:0] exp_g;

        // single packet of 5 from requester 0
        tbl[0]  = mk(1,0,0,0,1, 32'hA0,0,     2'b00,0,0,0, 32'h0);
        tbl[1]  = mk(1,0,0,0,1, 32'hA0,0,     2'b01,1,1,0, 32'hA0);
        tbl[2]  = mk(1,0,0,0,1, 32'hA1,0,     2'b01,1,1,0, 32'hA1);
        tbl[3]  = mk(1,0,0,0,1, 32'hA2,0,     2'b01,1,1,0, 32'hA2);
        tbl[4]  = mk(1,0,0,0,1, 32'hA3,0,     2'b01,1,1,0, 32'hA3);
        tbl[5]  = mk(1,0,1,0,1, 32'hA4,0,     2'b01,1,1,0, 32'hA4);
        tbl[6]  = mk(0,0,0,0,1, 0,0,          2'b00,0,0,0, 32'h0);
        tbl[7]  = mk(0,0,0,0,1, 0,0,          2'b00,0,0,0, 32'h0);
        // 4-word packet from requester 1 with tx_valid toggling
        tbl[8]  = mk(0,1,0,0,1, 0,32'hB0,     2'b00,0,0,0, 32'h0);
        tbl[9]  = mk(0,1,0,0,1, 0,32'hB0,     2'b10,1,0,1, 32'hB0);
        tbl[10] = mk(0,1,0,0,0, 0,32'hB1,     2'b10,0,0,0, 32'hB1);
        tbl[11] = mk(0,1,0,0,1, 0,32'hB1,     2'b10,1,0,1, 32'hB1);
        tbl[12] = mk(0,1,0,0,0, 0,32'hB2,     2'b10,0,0,0, 32'hB2);
        tbl[13] = mk(0,1,0,0,1, 0,32'hB2,     2'b10,1,0,1, 32'hB2);
        tbl[14] = mk(0,1,0,1,0, 0,32'hB3,     2'b10,0,0,0, 32'hB3);
        tbl[15] = mk(0,1,0,1,1, 0,32'hB3,     2'b10,1,0,1, 32'hB3);
        tbl[16] = mk(0,0,0,0,1, 0,0,          2'b00,0,0,0, 32'h0);
        tbl[17] = mk(1,0,0,0,0, 32'hC0,0,     2'b00,0,0,0, 32'h0);
        tbl[18] = mk(1,0,0,0,0, 32'hC0,0,     2'b01,0,0,0, 32'hC0);
        tbl[19] = mk(1,0,1,0,1, 32'hC0,0,     2'b01,1,1,0, 32'hC0);
        tbl[20] = mk(0,0,0,0,1, 0,0,          2'b00,0,0,0, 32'h0);
        tbl[21] = mk(0,0,0,0,0, 0,0,          2'b00,0,0,0, 32'h0);

        idle_inputs();
        #2;
        do_reset();

        for (int i = 0; i < 22; i++) step(tbl[i], i);
        chk("wcnt0_after_table", 32'(word_cnt0), 32'd6);
        chk("wcnt1_after_table", 32'(word_cnt1), 32'd4);

        // alternating 16-word bursts with continuous requests
        do_reset();
        req0 = 1; req1 = 1; tx_valid = 1; req_data0 = 32'hD0D0_0000; req_data1 = 32'hD1D1_0000;
        #1;
        for (int b = 0; b < 4; b++) begin
            idle_n = 0;
            while (!tx_write && idle_n < 10) begin
                idle_n++;
                tick();
            end
            chk($sformatf("alt%0d_gap", b), 32'(idle_n), (b == 0) ? 32'd1 : 32'd2);
            exp_g = (b % 2 == 0) ? 2'b01 : 2'b10;
            len = 0; bad = 0; bad_data = 0;
            while (tx_write && len < 40) begin
                if (grant !== exp_g) bad = 1;
                if (tx_data !== ((b % 2 == 0) ? req_data0 : req_data1)) bad_data = 1;
                len++;
                tick();
            end
            chk($sformatf("alt%0d_len", b), 32'(len), 32'd16);
            chk($sformatf("alt%0d_owner", b), 32'(bad), 32'd0);
            chk($sformatf("alt%0d_data", b), 32'(bad_data), 32'd0);
        end

        // stall timeout on requester 1, requester 0 pending
        do_reset();
        req1 = 1; tx_valid = 1; req_data1 = 32'h1111; req_data0 = 32'h2222;
        #1;
        chk("stall_idle_grant", 32'(grant), 32'h0);
        tick();
        req1 = 0; req0 = 1;
        #1;
        cnt = 0; bad = 0;
        while (grant == 2'b10 && cnt < 100) begin
            if (tx_write) bad = 1;
            cnt++;
            tick();
        end
        chk("stall_cycles", 32'(cnt), 32'd64);
        chk("stall_no_write", 32'(bad), 32'd0);
        chk("stall_gap_grant", 32'(grant), 32'h0);
        chk("stall_gap_write", 32'(tx_write), 32'h0);
        tick();
        chk("stall_idle2_grant", 32'(grant), 32'h0);
        tick();
        chk("stall_next_owner", 32'(grant), 32'h1);

        // tx_valid low with req high must hold indefinitely
        tx_valid = 0;
        #1;
        bad = 0;
        for (int k = 0; k < 70; k++) begin
            if (grant !== 2'b01 || tx_write !== 1'b0) bad = 1;
            tick();
        end
        chk("hold_no_revoke", 32'(bad), 32'd0);
        tx_valid = 1; req_last0 = 1;
        #1;
        chk("hold_write", 32'({tx_write, ack0, ack1}), 32'b110);
        tick();
        chk("hold_gap", 32'(grant), 32'h0);
        chk("hold_wcnt0", 32'(word_cnt0), 32'd1);

        // reset pulse during the 3rd word
        do_reset();
        req0 = 1; tx_valid = 1; req_data0 = 32'hE0;
        tick();
        tick();
        tick();
        chk("rstmid_write_before", 32'(tx_write), 32'd1);
        chk("rstmid_wcnt_before", 32'(word_cnt0), 32'd2);
        #2;
        rst = 0;
        #1;
        chk_all_zero("rstmid");
        tick();
        rst = 1;
        req1 = 1;
        #1;
        chk("rstmid_rel_grant", 32'(grant), 32'h0);
        chk("rstmid_rel_wcnt", {word_cnt1, word_cnt0}, 32'h0);
        tick();
        chk("rstmid_rr0", 32'(grant), 32'h1);

        // saturation of word_cnt0
        do_reset();
        s_req0 = 1;
        #1;
        n = 0; cyc = 0;
        while (n < 65540 && cyc < 70000) begin
            hit = s_ack0;
            if (s_ack0) n++;
            cyc++;
            tick();
            if (hit && (n == 65534 || n == 65535 || n == 65536 || n == 65540))
                chk($sformatf("sat_wcnt_at_%0d", n), 32'(s_wcnt0),
                    (n > 65535) ? 32'hFFFF : 32'(n));
        end
        chk("sat_words_accepted", 32'(n), 32'd65540);
        s_req0 = 0;
        repeat (3) tick();
        chk("sat_hold", 32'(s_wcnt0), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ft_tx_arbiter.md
FT_TX_ARBITER -- requirements
Module: ft_tx_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 Parameter BURST_MAX, default 16: maximum words per grant, legal range 1..255.
REQ-003 Parameter STALL_MAX, default 64: consecutive cycles a granted requester may hold req low before its grant is revoked, legal range 1..255.
REQ-004 Port clk_in  input  1  clock shared with the FT245 core tx_clk.
REQ-005 Port rst  input  1  asynchronous active-low reset.
REQ-006 Port req0 / req1  input  1  requester n has a word on req_data_n.
REQ-007 Port req_data0 / req_data1  input  32  word offered by requester n.
REQ-008 Port req_last0 / req_last1  input  1  the offered word is the last of its packet.
REQ-009 Port ack0 / ack1  output  1  the word on req_data_n is consumed this cycle.
REQ-010 Port tx_valid  input  1  the core TX FIFO can accept a word this cycle.
REQ-011 Port tx_write  output  1  write strobe to the core TX FIFO.
REQ-012 Port tx_data  output  32  word to the core TX FIFO.
REQ-013 Port grant  output  2  one-hot current owner, 2'b00 when idle.
REQ-014 Port word_cnt0 / word_cnt1  output  16  saturating count of words accepted per requester.

Function
REQ-015 States: IDLE, XFER0, XFER1, GAP; grant SHALL be 2'b01 in XFER0, 2'b10 in XFER1, and 2'b00 otherwise.
REQ-016 IDLE: if exactly one req is high, go to that requester's XFER next cycle; if both are high, go to the XFER of the requester selected by the round-robin pointer rr (0 selects requester 0).
REQ-017 In XFERn, tx_write SHALL equal reqn & tx_valid combinationally, and acks SHALL equal tx_write; the non-granted ack SHALL be 0.
REQ-018 tx_data SHALL equal req_datan in XFERn and 32'h0 in all other states.
REQ-019 Each accepted word (tx_write=1) SHALL increment burst counter bcnt, which is cleared on entry to XFER.
REQ-020 XFERn SHALL exit to GAP in the cycle after a word is accepted if any of the following holds: req_lastn=1 on that word, or bcnt reaches BURST_MAX.
REQ-021 In XFERn, the stall counter SHALL increment on each cycle with reqn=0 and clear on any cycle with reqn=1; when it reaches STALL_MAX, the state SHALL go to GAP with no word lost.
REQ-022 When tx_valid=0 and reqn=1, the state SHALL hold with no write and no increment of the stall counter.
REQ-023 On every exit from XFERn, rr SHALL be set to the other requester, so a continuously requesting pair alternates bursts.
REQ-024 GAP SHALL last exactly one cycle with tx_write=0, then go to IDLE; the minimum spacing between bursts is therefore 2 idle cycles.
REQ-025 word_cntn SHALL increment on each ackn and hold at 16'hFFFF without wrapping.
REQ-026 tx_write SHALL never be asserted when tx_valid=0.

Reset
REQ-027 While rst=0, the block SHALL hold: state=IDLE, rr=0, bcnt=0, stall counter=0, word_cnt0=word_cnt1=0, grant=0, tx_write=0, ack0=ack1=0, tx_data=0.
REQ-028 Reset asserted mid-burst SHALL force IDLE asynchronously; no write or ack SHALL occur in that cycle, and the partial packet is abandoned.

Verification
REQ-029 Only req0 is high, with a 5-word packet ending in last and tx_valid=1 -> grant=01 one cycle later, 5 consecutive writes, GAP, IDLE, word_cnt0=5.
REQ-030 Both requesters are high with long packets, BURST_MAX=16 -> bursts of 16 words alternate 0,1,0,1 with 2 idle cycles between bursts.
REQ-031 tx_valid is toggled 1,0,1,0 during a 4-word burst -> writes occur only on tx_valid=1 cycles, data order is preserved, and the burst completes after 7 cycles.
REQ-032 Granted req1 drops low for STALL_MAX=64 cycles -> the grant is revoked in cycle 64, GAP follows, and req0 is granted next if it is pending.
REQ-033 rst is pulsed low during the 3rd word of a burst -> all outputs are 0 immediately; after release, rr=0 and the counters are 0.
REQ-034 65540 words are accepted from requester 0 -> word_cnt0 reaches 16'hFFFF and holds there.
